pipe_issue_ctrl: RTL and testbench

Instruction issue controller placed in front of the 4-stage `pipe` ALU datapath (16×16 register bank, 256×16 memory, 4-bit func codes 0–11).
- Buffers incoming instructions in a small FIFO and issues at most one per cycle, in order.
- Inserts bubbles on read-after-write hazards against recently issued destinations, drops illegal opcodes, and supports a drain/flush sequence that signals completion.

---
 rtl/pipe_issue_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_issue_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_issue_ctrl.sv
// In-order issue controller for the 4-stage pipe: instruction FIFO, RAW scoreboard, illegal-opcode drop, drain/flush.
// Define PIPE_ISSUE_STATS_EN to add the saturating issue_cnt/stall_cnt statistics ports.
module pipe_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int HAZ_WIN = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_rs1,
  input  logic [3:0]  in_rs2,
  input  logic [3:0]  in_rd,
  input  logic [3:0]  in_func,
  input  logic [7:0]  in_addr,
  output logic        iss_valid,
  output logic [3:0]  iss_rs1,
  output logic [3:0]  iss_rs2,
  output logic [3:0]  iss_rd,
  output logic [3:0]  iss_func,
  output logic [7:0]  iss_addr,
  input  logic        flush,
  output logic        done,
  output logic        busy,
  output logic        err
`ifdef PIPE_ISSUE_STATS_EN
  ,
  output logic [15:0] issue_cnt,
  output logic [15:0] stall_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, STALL, DRAIN} state_t;
  state_t state;

  logic [23:0]        fifo_mem [DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr, count, count_next;
  logic [HAZ_WIN-1:0] sb_v;
  logic [3:0]         sb_rd [HAZ_WIN];

  logic [3:0] head_rs1, head_rs2, head_rd, head_func;
  logic [7:0] head_addr;
  logic       head_valid, illegal, hazard, push, do_pop, do_issue, do_stall;
  logic       sb_busy_next, empty_next;

  assign {head_rs1, head_rs2, head_rd, head_func, head_addr} = fifo_mem[rd_ptr[AW-1:0]];
  assign count      = wr_ptr - rd_ptr;
  assign head_valid = (count != '0);
  assign illegal    = (head_func >= 4'd12);
  assign in_ready   = (count != (AW+1)'(DEPTH)) && (state != DRAIN);
  assign busy       = (state != IDLE);

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++)
      if (sb_v[i] && (sb_rd[i] == head_rs1 || sb_rd[i] == head_rs2)) hazard = 1'b1;
  end

  assign push     = in_valid && in_ready;
  assign do_issue = head_valid && !illegal && !hazard;
  assign do_stall = head_valid && !illegal && hazard;
  assign do_pop   = head_valid && (illegal || !hazard);

  // Look one edge ahead so IDLE and done are reached as the last scoreboard slot drains.
  always_comb begin
    sb_busy_next = do_issue;
    for (int i = 0; i < HAZ_WIN - 1; i++) sb_busy_next = sb_busy_next | sb_v[i];
  end

  assign count_next = count + (AW+1)'(push) - (AW+1)'(do_pop);
  assign empty_next = (count_next == '0) && !sb_busy_next;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {in_rs1, in_rs2, in_rd, in_func, in_addr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      sb_v      <= '0;
      for (int i = 0; i < HAZ_WIN; i++) sb_rd[i] <= '0;
      iss_valid <= 1'b0;
      iss_rs1   <= '0;
      iss_rs2   <= '0;
      iss_rd    <= '0;
      iss_func  <= '0;
      iss_addr  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (head_valid && illegal) err <= 1'b1;

      // Bubbles shift an invalid slot so older destinations age out at the same rate.
      sb_v[0]  <= do_issue;
      sb_rd[0] <= head_rd;
      for (int i = 1; i < HAZ_WIN; i++) begin
        sb_v[i]  <= sb_v[i-1];
        sb_rd[i] <= sb_rd[i-1];
      end

      iss_valid <= do_issue;
      if (do_issue) begin
        iss_rs1  <= head_rs1;
        iss_rs2  <= head_rs2;
        iss_rd   <= head_rd;
        iss_func <= head_func;
        iss_addr <= head_addr;
      end

      done <= 1'b0;
      case (state)
        IDLE: begin
          if (flush)     state <= DRAIN;
          else if (push) state <= RUN;
        end
        RUN, STALL: begin
          if (flush)           state <= DRAIN;
          else if (do_stall)   state <= STALL;
          else if (empty_next) state <= IDLE;
          else                 state <= RUN;
        end
        DRAIN: begin
          if (empty_next) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIPE_ISSUE_STATS_EN
  // Statistics stop at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (do_issue && issue_cnt != 16'hFFFF) issue_cnt <= issue_cnt + 16'd1;
      if (do_stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  // No statistics registers in this build; issue and stall decisions are unchanged.
`endif

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Self-checking bench for pipe_issue_ctrl: directed vector table, corner-case sequences, and random traffic
// checked against a cycle-window reference model. Honours PIPE_ISSUE_STATS_EN for the counter ports.
module tb_pipe_issue_ctrl;
  localparam int DEPTH   = 4;
  localparam int HAZ_WIN = 3;

  typedef struct packed {
    logic [3:0] rs1, rs2, rd, func;
    logic [7:0] addr;
  } instr_t;

  typedef struct {
    logic   valid;
    instr_t ins;
    logic   fl;
    logic   exp_iss_valid;
    logic [3:0] exp_iss_rd;
    logic   exp_busy;
    logic   exp_err;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [3:0] rd;
  } issue_rec_t;

  logic clk = 1'b0;
  logic rst_n, drv_valid, flush;
  instr_t drv;
  logic in_ready, iss_valid, done, busy, err;
  logic [3:0] iss_rs1, iss_rs2, iss_rd, iss_func;
  logic [7:0] iss_addr;
`ifdef PIPE_ISSUE_STATS_EN
  logic [15:0] issue_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  pipe_issue_ctrl #(.DEPTH(DEPTH), .HAZ_WIN(HAZ_WIN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(drv_valid), .in_ready(in_ready),
    .in_rs1(drv.rs1), .in_rs2(drv.rs2), .in_rd(drv.rd), .in_func(drv.func), .in_addr(drv.addr),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_func(iss_func), .iss_addr(iss_addr),
    .flush(flush), .done(done), .busy(busy), .err(err)
`ifdef PIPE_ISSUE_STATS_EN
    , .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
`endif
  );

  int errors, checks;

  // Reference model: pending queue plus the edge number of every issue.
  instr_t     mq[$];
  issue_rec_t m_hist[$];
  int         m_cycle;
  logic       m_drain, m_err, m_done, m_iss_valid;
  instr_t     m_iss;
  int         m_issue_cnt, m_stall_cnt;

  vec_t   vecs[$];
  instr_t stream[$];
  instr_t pushed[$];
  logic [7:0] issued_addr[$];
  int idx, accepts, first_drop;
  logic rdy;

  function automatic instr_t mk(input int rs1, input int rs2, input int rd, input int func, input int addr);
    instr_t r;
    r.rs1  = rs1[3:0];
    r.rs2  = rs2[3:0];
    r.rd   = rd[3:0];
    r.func = func[3:0];
    r.addr = addr[7:0];
    return r;
  endfunction

  function automatic logic issuedSince(input int from_cyc);
    foreach (m_hist[i]) if (m_hist[i].cyc >= from_cyc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic dependsOnRecent(input instr_t h);
    foreach (m_hist[i])
      if (m_hist[i].cyc >= m_cycle - HAZ_WIN && (m_hist[i].rd == h.rs1 || m_hist[i].rd == h.rs2))
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    mq.delete();
    m_hist.delete();
    m_drain = 1'b0; m_err = 1'b0; m_done = 1'b0; m_iss_valid = 1'b0;
    m_iss = '0; m_issue_cnt = 0; m_stall_cnt = 0;
  endtask

  task automatic modelStep(input logic v, input instr_t ins, input logic fl);
    logic push_ok, issued;
    push_ok = v && (mq.size() < DEPTH) && !m_drain;
    issued  = 1'b0;
    if (mq.size() > 0) begin
      if (mq[0].func >= 4'd12) begin
        void'(mq.pop_front());
        m_err = 1'b1;
      end else if (dependsOnRecent(mq[0])) begin
        if (m_stall_cnt < 65535) m_stall_cnt++;
      end else begin
        m_iss  = mq.pop_front();
        issued = 1'b1;
        m_hist.push_back('{m_cycle, m_iss.rd});
        if (m_issue_cnt < 65535) m_issue_cnt++;
      end
    end
    m_iss_valid = issued;
    if (push_ok) mq.push_back(ins);
    m_done = 1'b0;
    if (m_drain) begin
      if (mq.size() == 0 && !issuedSince(m_cycle + 1 - HAZ_WIN)) begin
        m_done  = 1'b1;
        m_drain = 1'b0;
      end
    end else if (fl) begin
      m_drain = 1'b1;
    end
    m_cycle++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkModel();
    checkOutput("iss_valid", iss_valid, m_iss_valid);
    checkOutput("iss_fields", {iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}, m_iss);
    checkOutput("done", done, m_done);
    checkOutput("busy", busy, m_drain || mq.size() != 0 || issuedSince(m_cycle - HAZ_WIN));
    checkOutput("err", err, m_err);
    checkOutput("in_ready", in_ready, (mq.size() < DEPTH) && !m_drain);
`ifdef PIPE_ISSUE_STATS_EN
    checkOutput("issue_cnt", issue_cnt, m_issue_cnt);
    checkOutput("stall_cnt", stall_cnt, m_stall_cnt);
`endif
  endtask

  // Called at a falling edge: drive, step across one rising edge, then compare at the next falling edge.
  task automatic applyStimulus(input logic v, input instr_t ins, input logic fl);
    drv_valid = v;
    drv       = ins;
    flush     = fl;
    @(posedge clk);
    modelStep(v, ins, fl);
    @(negedge clk);
    checkModel();
  endtask

  task automatic addVec(input logic v, input instr_t ins, input logic ev, input int erd,
                        input logic eb, input logic ee);
    vec_t t;
    t.valid = v; t.ins = ins; t.fl = 1'b0;
    t.exp_iss_valid = ev; t.exp_iss_rd = erd[3:0]; t.exp_busy = eb; t.exp_err = ee;
    vecs.push_back(t);
  endtask

  initial begin
    errors = 0; checks = 0; m_cycle = 0;
    rst_n = 1'b0; drv_valid = 1'b0; drv = '0; flush = 1'b0;
    modelReset();

    // Independent burst, RAW pair, illegal opcode followed by a legal one.
    addVec(1, mk(3, 5, 10, 0, 8'h01), 0, 0, 1, 0);
    addVec(1, mk(3, 8, 12, 2, 8'h02), 1, 10, 1, 0);
    addVec(1, mk(7, 3, 13, 11, 8'h03), 1, 12, 1, 0);
    addVec(0, '0, 1, 13, 1, 0);
    addVec(0, '0, 0, 13, 1, 0);
    addVec(0, '0, 0, 13, 1, 0);
    addVec(0, '0, 0, 13, 0, 0);
    addVec(1, mk(3, 5, 10, 0, 8'h04), 0, 13, 1, 0);
    addVec(1, mk(10, 5, 14, 1, 8'h05), 1, 10, 1, 0);
    addVec(0, '0, 0, 10, 1, 0);
    addVec(0, '0, 0, 10, 1, 0);
    addVec(0, '0, 0, 10, 1, 0);
    addVec(0, '0, 1, 14, 1, 0);
    addVec(0, '0, 0, 14, 1, 0);
    addVec(0, '0, 0, 14, 1, 0);
    addVec(0, '0, 0, 14, 0, 0);
    addVec(1, mk(1, 2, 9, 13, 8'h06), 0, 14, 1, 0);
    addVec(1, mk(1, 2, 4, 0, 8'h07), 0, 14, 1, 1);
    addVec(0, '0, 1, 4, 1, 1);
    addVec(0, '0, 0, 4, 1, 1);
    addVec(0, '0, 0, 4, 1, 1);
    addVec(0, '0, 0, 4, 0, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkModel();
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_iss_valid", iss_valid, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid, vecs[i].ins, vecs[i].fl);
      checkOutput("tbl_iss_valid", iss_valid, vecs[i].exp_iss_valid);
      checkOutput("tbl_iss_rd", iss_rd, vecs[i].exp_iss_rd);
      checkOutput("tbl_busy", busy, vecs[i].exp_busy);
      checkOutput("tbl_err", err, vecs[i].exp_err);
      checkOutput("tbl_done", done, 0);
    end

    // Full FIFO: DEPTH+2 instructions held behind a dependent head.
    stream.delete(); pushed.delete(); issued_addr.delete();
    stream.push_back(mk(2, 2, 3, 0, 8'h21));
    for (int k = 0; k < 5; k++) stream.push_back(mk(5, 6, 8 + k, 0, 8'h22 + k));
    pushed.push_back(mk(1, 1, 2, 0, 8'h20));
    applyStimulus(1'b1, pushed[0], 1'b0);
    idx = 0; accepts = 0; first_drop = -1;
    for (int cyc = 0; cyc < 40 && issued_addr.size() < 7; cyc++) begin
      rdy = in_ready;
      if (idx < 6) begin
        if (rdy) begin
          pushed.push_back(stream[idx]);
          accepts++;
        end else if (first_drop < 0) begin
          first_drop = accepts;
        end
        applyStimulus(1'b1, stream[idx], 1'b0);
        if (rdy) idx++;
      end else begin
        applyStimulus(1'b0, '0, 1'b0);
      end
      if (iss_valid) issued_addr.push_back(iss_addr);
    end
    checkOutput("fifo_accepts_before_full", first_drop, 4);
    checkOutput("fifo_issue_count", issued_addr.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < issued_addr.size()) checkOutput("fifo_issue_order", issued_addr[i], pushed[i].addr);
    for (int k = 0; k < 20 && busy; k++) applyStimulus(1'b0, '0, 1'b0);

    // Flush with two instructions in flight; flush held a second cycle inside DRAIN.
    applyStimulus(1'b1, mk(1, 1, 5, 0, 8'h30), 1'b0);
    applyStimulus(1'b1, mk(2, 2, 6, 0, 8'h31), 1'b1);
    checkOutput("flush_in_ready", in_ready, 0);
    checkOutput("flush_first_issue", {iss_valid, iss_addr}, {1'b1, 8'h30});
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("flush_second_issue", {iss_valid, iss_addr}, {1'b1, 8'h31});
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("flush_done_timing", done, (k == 3));
      checkOutput("flush_busy", busy, (k < 3));
    end

    // Reset asserted while the head is stalled.
    applyStimulus(1'b1, mk(1, 1, 2, 0, 8'h40), 1'b0);
    applyStimulus(1'b1, mk(2, 2, 3, 0, 8'h41), 1'b0);
    applyStimulus(1'b1, mk(4, 4, 5, 0, 8'h42), 1'b0);
    checkOutput("pre_reset_busy", busy, 1);
    checkOutput("pre_reset_err", err, 1);
    rst_n = 1'b0;
    drv_valid = 1'b0;
    #1;
    modelReset();
    checkModel();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("post_reset_in_ready", in_ready, 1);
      checkOutput("post_reset_no_issue", iss_valid, 0);
    end

    // Random traffic with a small register range so hazards are frequent.
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 9) < 7,
                    mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 15), $urandom_range(0, 255)),
                    $urandom_range(0, 39) == 0);
    end
    for (int k = 0; k < 20; k++) applyStimulus(1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
